// File: rtl/cordic_iteration_sequencer.sv
// Iteration sequencer for the iterative CORDIC datapath: load/iterate strobes, shift schedule, termination.
// Optional early termination on a zero residual is compiled in with `define CORDIC_EARLY_TERM_EN.
module cordic_iteration_sequencer #(
  parameter int unsigned BIT_WIDTH  = 64,
  parameter int unsigned ITERATIONS = BIT_WIDTH,
  parameter int unsigned IDX_W      = $clog2(ITERATIONS),
  parameter int unsigned CNT_W      = $clog2(ITERATIONS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode_bit,
  input  logic [1:0]           coordinate_system,
  input  logic [BIT_WIDTH-1:0] y_residual,
  input  logic [BIT_WIDTH-1:0] z_residual,
  output logic                 busy,
  output logic                 load,
  output logic                 iter_en,
  output logic [IDX_W-1:0]     shift_idx,
  output logic [CNT_W-1:0]     iter_count,
  output logic                 done,
  output logic                 term_cause
);

  localparam int unsigned      REP_W     = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ITERATIONS - 1);
  localparam logic [REP_W-1:0] FIRST_REP = REP_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             hyp_q, hyp_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             cause_q, cause_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             converged;
  logic             repeat_now;

`ifdef CORDIC_EARLY_TERM_EN
  assign converged = (mode_q ? (y_residual == '0) : (z_residual == '0)) && (cnt_q >= CNT_W'(2));
`else
  logic unused_residuals;
  assign unused_residuals = ^{y_residual, z_residual, mode_q};
  assign converged        = 1'b0;
`endif

  assign repeat_now = hyp_q && ({2'b00, idx_q} == rep_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hyp_d   = hyp_q;
    step_d  = 1'b0;
    busy_d  = busy_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    cause_d = cause_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = mode_bit;
          hyp_d   = coordinate_system[1];
          busy_d  = 1'b1;
          load_d  = 1'b1;
          cause_d = 1'b0;
          cnt_d   = '0;
          idx_d   = coordinate_system[1] ? IDX_W'(1) : '0;
          rep_d   = FIRST_REP;
        end
      end
      S_LOAD: begin
        state_d = S_ITER;
        step_d  = 1'b1;
      end
      S_ITER: begin
        // step_q low means the schedule is exhausted, so it also wins term_cause over converged.
        if (!step_q || converged) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cause_d = step_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (repeat_now) begin
            rep_d = REP_W'(rep_q * 3 + 1);
          end else begin
            idx_d = idx_q + 1'b1;
          end
          step_d = !((idx_q == LAST_IDX) && !repeat_now);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      hyp_q   <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      cause_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hyp_q   <= hyp_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  // iter_en is the registered schedule strobe, dropped in the same cycle the watched residual reads zero.
  assign iter_en    = step_q & ~converged;
  assign busy       = busy_q;
  assign load       = load_q;
  assign shift_idx  = idx_q;
  assign iter_count = cnt_q;
  assign done       = done_q;
  assign term_cause = cause_q;

endmodule

// File: tb/tb_cordic_iteration_sequencer.sv
// Self-checking bench for cordic_iteration_sequencer (N=16) against a schedule model built from index rules.
module tb_cordic_iteration_sequencer;

  localparam int unsigned N  = 16;
  localparam int unsigned BW = 16;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(N) + 1;
`ifdef CORDIC_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int NEVER = 1000;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mode_bit;
  logic [1:0]    coordinate_system;
  logic [BW-1:0] y_residual;
  logic [BW-1:0] z_residual;
  logic          busy;
  logic          load;
  logic          iter_en;
  logic [IW-1:0] shift_idx;
  logic [CW-1:0] iter_count;
  logic          done;
  logic          term_cause;

  cordic_iteration_sequencer #(
    .BIT_WIDTH (BW),
    .ITERATIONS(N)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mode_bit         (mode_bit),
    .coordinate_system(coordinate_system),
    .y_residual       (y_residual),
    .z_residual       (z_residual),
    .busy             (busy),
    .load             (load),
    .iter_en          (iter_en),
    .shift_idx        (shift_idx),
    .iter_count       (iter_count),
    .done             (done),
    .term_cause       (term_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int sched[$];
  int last_cnt = 0;
  int last_cause = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Shift schedule from the index rules: 0..N-1, or 1..N-1 with 4, 13, 40 issued twice.
  task automatic build_sched(input bit hyp);
    sched.delete();
    if (hyp) begin
      for (int i = 1; i < int'(N); i++) begin
        sched.push_back(i);
        if (i == 4 || i == 13 || i == 40) sched.push_back(i);
      end
    end else begin
      for (int i = 0; i < int'(N); i++) sched.push_back(i);
    end
  endtask

  // Watched residual reads zero once k0 iterations are complete (cycle 2+k0 onward).
  task automatic drive_res(input int c, input bit m, input int k0, input bit other_zero);
    logic [BW-1:0] w;
    logic [BW-1:0] o;
    w = (c >= 2 + k0) ? '0 : BW'($urandom_range(1, 65535));
    o = other_zero ? '0 : BW'($urandom_range(1, 65535));
    if (m) begin
      y_residual = w;
      z_residual = o;
    end else begin
      z_residual = w;
      y_residual = o;
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, " busy"}, 32'(busy), 32'(0));
    chk({tag, " load"}, 32'(load), 32'(0));
    chk({tag, " iter_en"}, 32'(iter_en), 32'(0));
    chk({tag, " done"}, 32'(done), 32'(0));
    chk({tag, " iter_count"}, 32'(iter_count), 32'(last_cnt));
    chk({tag, " term_cause"}, 32'(term_cause), 32'(last_cause));
  endtask

  task automatic run_op(input string name, input bit hyp, input bit lin, input bit m,
                        input int k0, input bit other_zero, input bit disturb);
    int total;
    int conv_at;
    int mm;
    int cause;
    int exp_cnt;
    bit exp_it;
    build_sched(hyp);
    total   = sched.size();
    conv_at = (k0 < 2) ? 2 : k0;
    if (EARLY && conv_at < total) begin
      mm    = conv_at;
      cause = 1;
    end else begin
      mm    = total;
      cause = 0;
    end
    idle_check({name, " idle"});
    start             = 1'b1;
    mode_bit          = m;
    coordinate_system = hyp ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, lin};
    drive_res(0, m, k0, other_zero);
    for (int c = 1; c <= mm + 3; c++) begin
      @(negedge clk);
      if (disturb) start = (c > mm) ? 1'b1 : 1'($urandom_range(0, 1));
      else         start = 1'b0;
      mode_bit          = 1'($urandom_range(0, 1));
      coordinate_system = 2'($urandom_range(0, 3));
      drive_res(c, m, k0, other_zero);
      #1;
      exp_it  = (c >= 2) && (c <= mm + 1);
      exp_cnt = (c < 2) ? 0 : ((c - 2 > mm) ? mm : c - 2);
      chk($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(1));
      chk($sformatf("%s load c%0d", name, c), 32'(load), 32'(c == 1));
      chk($sformatf("%s iter_en c%0d", name, c), 32'(iter_en), 32'(exp_it));
      chk($sformatf("%s done c%0d", name, c), 32'(done), 32'(c == mm + 3));
      chk($sformatf("%s iter_count c%0d", name, c), 32'(iter_count), 32'(exp_cnt));
      chk($sformatf("%s term_cause c%0d", name, c), 32'(term_cause), 32'((c == mm + 3) ? cause : 0));
      if (c == 1 || exp_it)
        chk($sformatf("%s shift_idx c%0d", name, c), 32'(shift_idx), 32'(sched[(c < 2) ? 0 : c - 2]));
    end
    last_cnt   = mm;
    last_cause = cause;
  endtask

  initial begin
    rst               = 1'b1;
    start             = 1'b1;
    mode_bit          = 1'b0;
    coordinate_system = 2'b00;
    y_residual        = '0;
    z_residual        = '0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst load", 32'(load), 32'(0));
    chk("rst iter_en", 32'(iter_en), 32'(0));
    chk("rst shift_idx", 32'(shift_idx), 32'(0));
    chk("rst iter_count", 32'(iter_count), 32'(0));
    chk("rst done", 32'(done), 32'(0));
    chk("rst term_cause", 32'(term_cause), 32'(0));

    run_op("circ_rot", 1'b0, 1'b0, 1'b0, NEVER, 1'b0, 1'b0);
    run_op("hyp", 1'b1, 1'b0, 1'b0, NEVER, 1'b0, 1'b0);
    run_op("vec_k3", 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0);
    run_op("vec_k1", 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0);

    // Reset in the middle of a circular run: nothing completes.
    idle_check("pre_rst idle");
    start             = 1'b1;
    mode_bit          = 1'b0;
    coordinate_system = 2'b00;
    drive_res(0, 1'b0, NEVER, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      drive_res(c, 1'b0, NEVER, 1'b0);
      if (c == 8) rst = 1'b1;
      #1;
      chk($sformatf("mid busy c%0d", c), 32'(busy), 32'(1));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst busy", 32'(busy), 32'(0));
    chk("mid_rst load", 32'(load), 32'(0));
    chk("mid_rst iter_en", 32'(iter_en), 32'(0));
    chk("mid_rst shift_idx", 32'(shift_idx), 32'(0));
    chk("mid_rst iter_count", 32'(iter_count), 32'(0));
    chk("mid_rst done", 32'(done), 32'(0));
    chk("mid_rst term_cause", 32'(term_cause), 32'(0));
    last_cnt   = 0;
    last_cause = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst done c%0d", c), 32'(done), 32'(0));
    end

    run_op("clean", 1'b0, 1'b0, 1'b0, NEVER, 1'b0, 1'b0);
    run_op("dist_circ", 1'b0, 1'b0, 1'b0, NEVER, 1'b0, 1'b1);
    run_op("dist_hyp", 1'b1, 1'b0, 1'b1, NEVER, 1'b1, 1'b1);
    run_op("rot_z0", 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_op("lin_vec", 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      run_op($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
    idle_check("final idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
